// File: rtl/pbit_link_pkg.sv
// Shared definitions for the inter-FPGA p-bit link: link widths, beat count helper, framer FSM states.
package pbit_link_pkg;

   localparam int unsigned DATA_WIDTH_FMC     = 30;
   localparam int unsigned DATA_WIDTH_FMCPLUS = 54;

   // CHK is only reachable when the checksum beat is built.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      CHK  = 2'd2
   } pbit_tx_state_t;

   // Beats needed to carry n bits over a w-bit link.
   function automatic int unsigned num_beats(input int unsigned n, input int unsigned w);
      return (n + w - 1) / w;
   endfunction

endpackage

// File: rtl/pbit_frame_tx.sv
// Transmit framer: snapshots NUM_PBITS p-bits and streams them LSB-first as zero-padded
// DATA_WIDTH beats with back-pressure, back-to-back frames and drop reporting.
// Optional checksum beat (XOR of all data beats) when PBIT_LINK_CHECKSUM_EN is defined.
module pbit_frame_tx
   import pbit_link_pkg::*;
#(
   parameter int unsigned NUM_PBITS  = 1369,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_FMC
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [NUM_PBITS-1:0]  pbits_in,
   input  logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   output logic                  tx_last,
   output logic                  busy,
   output logic                  done,
   output logic                  start_dropped,
   output logic [15:0]           frame_cnt
);

   localparam int unsigned NUM_BEATS  = num_beats(NUM_PBITS, DATA_WIDTH);
   localparam int unsigned TOTAL_BITS = NUM_BEATS * DATA_WIDTH;
   localparam int unsigned IDX_W      = $clog2(NUM_BEATS + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

   pbit_tx_state_t          state, state_n;
   logic [TOTAL_BITS-1:0]   shadow, shadow_n;
   logic [IDX_W-1:0]        beat_idx, beat_idx_n;
   logic [DATA_WIDTH-1:0]   tx_data_n;
   logic                    tx_valid_n, tx_last_n, busy_n, done_n, drop_n;
   logic [15:0]             frame_cnt_n;
   logic                    hs, load, finish;
`ifdef PBIT_LINK_CHECKSUM_EN
   logic [DATA_WIDTH-1:0]   chk, chk_n;
`endif

   // Next-state and next-output logic; every output is computed here and registered below.
   always_comb begin
      state_n     = state;
      shadow_n    = shadow;
      beat_idx_n  = beat_idx;
      tx_data_n   = tx_data;
      tx_valid_n  = tx_valid;
      tx_last_n   = tx_last;
      done_n      = 1'b0;
      drop_n      = 1'b0;
      frame_cnt_n = frame_cnt;
      load        = 1'b0;
      finish      = 1'b0;
      hs          = tx_valid && tx_ready;
`ifdef PBIT_LINK_CHECKSUM_EN
      chk_n       = chk;
`endif

      case (state)
         IDLE: load = start;
         SEND: begin
            if (hs) begin
`ifdef PBIT_LINK_CHECKSUM_EN
               chk_n = chk ^ tx_data;
`endif
               if (beat_idx == LAST_IDX) begin
`ifdef PBIT_LINK_CHECKSUM_EN
                  state_n   = CHK;
                  tx_data_n = chk ^ tx_data;
                  tx_last_n = 1'b1;
`else
                  finish = 1'b1;
`endif
               end else begin
                  beat_idx_n = beat_idx + 1'b1;
                  tx_data_n  = shadow[int'(beat_idx_n) * DATA_WIDTH +: DATA_WIDTH];
`ifdef PBIT_LINK_CHECKSUM_EN
                  tx_last_n  = 1'b0;
`else
                  tx_last_n  = (beat_idx_n == LAST_IDX);
`endif
               end
            end
         end
`ifdef PBIT_LINK_CHECKSUM_EN
         CHK: finish = hs;
`endif
         default: state_n = IDLE;
      endcase

      // Frame completion; a start in the same cycle chains the next frame with no bubble.
      if (finish) begin
         done_n      = 1'b1;
         frame_cnt_n = frame_cnt + 16'd1;
         load        = start;
         if (!start) begin
            state_n    = IDLE;
            tx_valid_n = 1'b0;
            tx_last_n  = 1'b0;
            tx_data_n  = '0;
         end
      end

      if (load) begin
         shadow_n   = TOTAL_BITS'(pbits_in);
         beat_idx_n = '0;
         state_n    = SEND;
         tx_valid_n = 1'b1;
         tx_data_n  = shadow_n[DATA_WIDTH-1:0];
`ifdef PBIT_LINK_CHECKSUM_EN
         chk_n      = '0;
         tx_last_n  = 1'b0;
`else
         tx_last_n  = (NUM_BEATS == 1);
`endif
      end

      drop_n = start && (state != IDLE) && !finish;
      busy_n = (state_n != IDLE);
   end

   // State, shadow and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         shadow        <= '0;
         beat_idx      <= '0;
         tx_data       <= '0;
         tx_valid      <= 1'b0;
         tx_last       <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         start_dropped <= 1'b0;
         frame_cnt     <= '0;
`ifdef PBIT_LINK_CHECKSUM_EN
         chk           <= '0;
`endif
      end else begin
         state         <= state_n;
         shadow        <= shadow_n;
         beat_idx      <= beat_idx_n;
         tx_data       <= tx_data_n;
         tx_valid      <= tx_valid_n;
         tx_last       <= tx_last_n;
         busy          <= busy_n;
         done          <= done_n;
         start_dropped <= drop_n;
         frame_cnt     <= frame_cnt_n;
`ifdef PBIT_LINK_CHECKSUM_EN
         chk           <= chk_n;
`endif
      end
   end

endmodule

// File: tb/tb_pbit_frame_tx.sv
// Directed bench for pbit_frame_tx: a 7/3 instance for framing scenarios and a 1369/30 instance
// for the default geometry. Expectations follow PBIT_LINK_CHECKSUM_EN when it is defined.
module tb_pbit_frame_tx;

`ifdef PBIT_LINK_CHECKSUM_EN
   localparam int NBT = 4;
   localparam int NBB = 47;
   localparam bit CHK_ON = 1'b1;
`else
   localparam int NBT = 3;
   localparam int NBB = 46;
   localparam bit CHK_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // small instance
   logic        s_start = 1'b0;
   logic [6:0]  s_pbits = '0;
   logic        s_ready = 1'b1;
   logic [2:0]  s_data;
   logic        s_valid, s_last, s_busy, s_done, s_drop;
   logic [15:0] s_cnt;

   // default-geometry instance
   logic          b_start = 1'b0;
   logic [1368:0] b_pbits = '0;
   logic          b_ready = 1'b1;
   logic [29:0]   b_data;
   logic          b_valid, b_last, b_busy, b_done, b_drop;
   logic [15:0]   b_cnt;

   pbit_frame_tx #(.NUM_PBITS(7), .DATA_WIDTH(3)) u_small (
      .clk(clk), .rst(rst), .start(s_start), .pbits_in(s_pbits), .tx_ready(s_ready),
      .tx_data(s_data), .tx_valid(s_valid), .tx_last(s_last), .busy(s_busy),
      .done(s_done), .start_dropped(s_drop), .frame_cnt(s_cnt)
   );

   pbit_frame_tx u_big (
      .clk(clk), .rst(rst), .start(b_start), .pbits_in(b_pbits), .tx_ready(b_ready),
      .tx_data(b_data), .tx_valid(b_valid), .tx_last(b_last), .busy(b_busy),
      .done(b_done), .start_dropped(b_drop), .frame_cnt(b_cnt)
   );

   int pass_cnt = 0;
   int total = 0;
   logic [15:0] cnt_exp = '0;
   logic [2:0] beats_a [4];
   logic [2:0] beats_b [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      total++;
      if ({s_data, s_valid, s_last, s_busy, s_done, s_drop, s_cnt} !== '0 ||
          {b_data, b_valid, b_last, b_busy, b_done, b_drop, b_cnt} !== '0) begin
         $display("FAIL reset_outputs small=%h big=%h want 0",
                  {s_data, s_valid, s_last, s_busy, s_done, s_drop, s_cnt},
                  {b_data, b_valid, b_last, b_busy, b_done, b_drop, b_cnt});
      end else pass_cnt++;
   endtask

   // One frame of 7'b1111010 with tx_ready high.
   task automatic test_basic(input string tag);
      s_pbits = 7'b1111010;
      s_ready = 1'b1;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      for (int i = 0; i < NBT; i++) begin
         total++;
         if (s_valid !== 1'b1 || s_data !== beats_a[i] || s_last !== (i == NBT - 1) || s_busy !== 1'b1) begin
            $display("FAIL %s_beat%0d got v=%b d=%b l=%b b=%b want v=1 d=%b l=%b b=1",
                     tag, i, s_valid, s_data, s_last, s_busy, beats_a[i], (i == NBT - 1));
         end else pass_cnt++;
         tick();
      end
      cnt_exp = cnt_exp + 16'd1;
      total++;
      if (s_done !== 1'b1 || s_valid !== 1'b0 || s_busy !== 1'b0 || s_cnt !== cnt_exp) begin
         $display("FAIL %s_done got done=%b v=%b b=%b cnt=%0d want done=1 v=0 b=0 cnt=%0d",
                  tag, s_done, s_valid, s_busy, s_cnt, cnt_exp);
      end else pass_cnt++;
      tick();
      total++;
      if (s_done !== 1'b0 || s_drop !== 1'b0) begin
         $display("FAIL %s_done_pulse got done=%b drop=%b want 0 0", tag, s_done, s_drop);
      end else pass_cnt++;
   endtask

   // tx_ready low for 5 cycles while beat 1 is presented.
   task automatic test_stall();
      s_pbits = 7'b1111010;
      s_ready = 1'b1;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      total++;
      if (s_data !== 3'b010 || s_valid !== 1'b1) begin
         $display("FAIL stall_beat0 got v=%b d=%b want v=1 d=010", s_valid, s_data);
      end else pass_cnt++;
      tick();
      s_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (s_data !== 3'b111 || s_valid !== 1'b1 || s_last !== 1'b0) begin
            $display("FAIL stall_hold%0d got v=%b d=%b l=%b want v=1 d=111 l=0", i, s_valid, s_data, s_last);
         end else pass_cnt++;
         tick();
      end
      total++;
      if (s_data !== 3'b111 || s_valid !== 1'b1) begin
         $display("FAIL stall_hold_end got v=%b d=%b want v=1 d=111", s_valid, s_data);
      end else pass_cnt++;
      s_ready = 1'b1;
      for (int i = 2; i < NBT; i++) begin
         tick();
         total++;
         if (s_data !== beats_a[i] || s_valid !== 1'b1 || s_last !== (i == NBT - 1)) begin
            $display("FAIL stall_beat%0d got v=%b d=%b l=%b want v=1 d=%b l=%b",
                     i, s_valid, s_data, s_last, beats_a[i], (i == NBT - 1));
         end else pass_cnt++;
      end
      tick();
      cnt_exp = cnt_exp + 16'd1;
      total++;
      if (s_done !== 1'b1 || s_cnt !== cnt_exp || s_valid !== 1'b0) begin
         $display("FAIL stall_done got done=%b cnt=%0d v=%b want done=1 cnt=%0d v=0", s_done, s_cnt, s_valid, cnt_exp);
      end else pass_cnt++;
      tick();
   endtask

   // start held high for three frames; pbits_in changes after the first snapshot.
   task automatic test_back_to_back();
      logic [2:0]  exp_d;
      logic        exp_done, exp_drop;
      logic [15:0] base;
      base = cnt_exp;
      s_pbits = 7'b1111010;
      s_ready = 1'b1;
      s_start = 1'b1;
      for (int k = 1; k <= 3 * NBT; k++) begin
         tick();
         if (k == 1) s_pbits = 7'b0000101;
         exp_d    = (k <= NBT) ? beats_a[(k - 1) % NBT] : beats_b[(k - 1) % NBT];
         exp_done = (k > 1) && ((k - 1) % NBT == 0);
         exp_drop = (k >= 2) && ((k - 2) % NBT != NBT - 1);
         cnt_exp  = base + 16'((k - 1) / NBT);
         total++;
         if (s_valid !== 1'b1 || s_data !== exp_d || s_done !== exp_done ||
             s_drop !== exp_drop || s_cnt !== cnt_exp) begin
            $display("FAIL b2b_cycle%0d got v=%b d=%b done=%b drop=%b cnt=%0d want v=1 d=%b done=%b drop=%b cnt=%0d",
                     k, s_valid, s_data, s_done, s_drop, s_cnt, exp_d, exp_done, exp_drop, cnt_exp);
         end else pass_cnt++;
         if (k == 3 * NBT) s_start = 1'b0;
      end
      tick();
      cnt_exp = base + 16'd3;
      total++;
      if (s_done !== 1'b1 || s_valid !== 1'b0 || s_cnt !== cnt_exp || s_drop !== 1'b0) begin
         $display("FAIL b2b_end got done=%b v=%b cnt=%0d drop=%b want done=1 v=0 cnt=%0d drop=0",
                  s_done, s_valid, s_cnt, s_drop, cnt_exp);
      end else pass_cnt++;
      tick();
   endtask

   // Asynchronous reset during beat 1 aborts the frame with no done.
   task automatic test_reset_mid();
      int seen_done;
      s_pbits = 7'b1111010;
      s_ready = 1'b1;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      tick();
      total++;
      if (s_data !== 3'b111 || s_valid !== 1'b1) begin
         $display("FAIL rstmid_beat1 got v=%b d=%b want v=1 d=111", s_valid, s_data);
      end else pass_cnt++;
      #1;
      rst = 1'b1;
      #1;
      total++;
      if ({s_data, s_valid, s_last, s_busy, s_done, s_drop, s_cnt} !== '0) begin
         $display("FAIL rstmid_async got %h want 0", {s_data, s_valid, s_last, s_busy, s_done, s_drop, s_cnt});
      end else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cnt_exp = '0;
      seen_done = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (s_done !== 1'b0 || s_valid !== 1'b0) seen_done++;
      end
      total++;
      if (seen_done != 0) begin
         $display("FAIL rstmid_no_done got %0d active cycles want 0", seen_done);
      end else pass_cnt++;
   endtask

   // Default 1369/30 geometry: 46 data beats, top 11 bits of beat 45 zero.
   task automatic test_default_geometry();
      logic [1379:0] pad;
      logic [29:0]   exp_d, csum;
      int            bad;
      for (int i = 0; i < 1369; i++) b_pbits[i] = 1'($urandom_range(0, 1));
      b_pbits[1368:1350] = 19'h7FFFF;
      pad  = 1380'(b_pbits);
      csum = '0;
      for (int i = 0; i < 46; i++) csum = csum ^ pad[i * 30 +: 30];
      b_ready = 1'b1;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      bad = 0;
      for (int i = 0; i < NBB; i++) begin
         exp_d = (i < 46) ? pad[i * 30 +: 30] : csum;
         if (b_valid !== 1'b1 || b_data !== exp_d || b_last !== (i == NBB - 1)) begin
            bad++;
            $display("FAIL big_beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                     i, b_valid, b_data, b_last, exp_d, (i == NBB - 1));
         end
         if (i == 45) begin
            total++;
            if (b_data[29:19] !== 11'd0 || b_data[18:0] !== 19'h7FFFF) begin
               $display("FAIL big_pad got %h want 0007ffff", b_data);
            end else pass_cnt++;
         end
         tick();
      end
      total++;
      if (bad != 0) begin
         $display("FAIL big_beats got %0d bad beats want 0", bad);
      end else pass_cnt++;
      total++;
      if (b_done !== 1'b1 || b_cnt !== 16'd1 || b_valid !== 1'b0) begin
         $display("FAIL big_done got done=%b cnt=%0d v=%b want done=1 cnt=1 v=0", b_done, b_cnt, b_valid);
      end else pass_cnt++;
      tick();
   endtask

   initial begin
      beats_a[0] = 3'b010; beats_a[1] = 3'b111; beats_a[2] = 3'b001; beats_a[3] = 3'b100;
      beats_b[0] = 3'b101; beats_b[1] = 3'b000; beats_b[2] = 3'b000; beats_b[3] = 3'b101;
      if (!CHK_ON) begin
         beats_a[3] = 3'b000;
         beats_b[3] = 3'b000;
      end
      #1;
      test_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      tick();
      test_reset();
      test_basic("basic");
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_basic("after_rst");
      test_default_geometry();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/pbit_frame_tx.md
# pbit_frame_tx

Parametrised transmit framer for inter-FPGA p-bit exchange. It snapshots a vector of NUM_PBITS p-bit states and streams it over a DATA_WIDTH-wide FMC/FMC+ link. The frame is ceil(NUM_PBITS/DATA_WIDTH) beats, zero-padded. It adds link back-pressure, back-to-back frames, drop reporting and an optional checksum beat. One instance sits per direction, per link, between the local p-bit array and the link I/O.

## Interface
- NUM_PBITS, 1369: p-bits actually sent per frame (≥1)
- DATA_WIDTH, 30: link beat width; 30 for FMC, 54 for FMC+
- clk  in  1  single clock for the block
- rst  in  1  asynchronous, active-high reset
- start  in  1  request to snapshot pbits_in and send one frame
- pbits_in  in  NUM_PBITS  p-bit states, sampled only on an accepted start
- tx_ready  in  1  link can accept a beat this cycle
- tx_data  out  DATA_WIDTH  current beat
- tx_valid  out  1  tx_data is valid
- tx_last  out  1  final beat of the frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the final beat handshake
- start_dropped  out  1  one-cycle pulse when a start is ignored
- frame_cnt  out  16  completed frames, wraps at 2^16

## Operation
- Derived constants:
  - NUM_BEATS = (NUM_PBITS+DATA_WIDTH-1)/DATA_WIDTH
  - TOTAL_BITS = NUM_BEATS*DATA_WIDTH
- FSM states: IDLE, SEND, CHK (CHK exists only with the macro).
- IDLE:
  - start=1 latches {zeros, pbits_in} into a TOTAL_BITS shadow register.
  - Clears beat_idx and the checksum, then goes to SEND.
- SEND:
  - tx_valid=1 and tx_data = shadow[beat_idx*DATA_WIDTH +: DATA_WIDTH].
  - Beat 0 carries p-bits [DATA_WIDTH-1:0]; ordering is LSB first.
  - A beat is consumed only when tx_valid && tx_ready. On each consumed beat, beat_idx increments and the beat is XORed into the checksum.
  - tx_valid and tx_data hold unchanged while tx_ready=0.
  - tx_last=1 when beat_idx==NUM_BEATS-1 (macro off).
- End of frame, on the final handshake:
  - done pulses and frame_cnt increments.
  - If start=1 in that same cycle, a new snapshot is taken and the FSM stays in SEND with beat_idx=0, giving no bubble.
  - Otherwise the FSM returns to IDLE.
- start while busy, excluding the final-handshake cycle, is ignored and start_dropped pulses. The shadow register is never altered mid-frame.
- busy = (state != IDLE).
- Padding bits [TOTAL_BITS-1:NUM_PBITS] are always 0.
- rst asserted mid-frame aborts the frame immediately; no done pulse is produced.

## Timing
- Reset values:
  - tx_data=0, tx_valid=0, tx_last=0, busy=0, done=0, start_dropped=0, frame_cnt=0.
  - State is IDLE; the shadow register is 0.
- Latency: start in cycle t → first beat has tx_valid=1 in cycle t+1.
- Throughput: NUM_BEATS cycles per frame with tx_ready held high, NUM_BEATS+1 with the macro. Back-to-back frames stream with no gap.
- done, frame_cnt and start_dropped are registered. done and frame_cnt update in the cycle after the final handshake.
- All outputs are registered; there is no combinational path from tx_ready to tx_valid or tx_data.
- beat_idx width is $clog2(NUM_BEATS+1).

## Configuration
- PBIT_LINK_CHECKSUM_EN defined:
  - After data beat NUM_BEATS-1, the FSM enters CHK and sends one extra beat carrying the XOR of all data beats.
  - tx_last asserts on the checksum beat only, and done follows its handshake.
  - The back-to-back rule applies to the checksum handshake.
- PBIT_LINK_CHECKSUM_EN undefined: CHK and the checksum register are not built; frames are data beats only.

## Structure
- The shared package pbit_link_pkg holds:
  - function num_beats(n,w) returning (n+w-1)/w
  - the link width constants DATA_WIDTH_FMC=30 and DATA_WIDTH_FMCPLUS=54
  - the FSM state typedef pbit_tx_state_t
- The block is a single module; no sub-module is warranted. The checksum is an inline XOR accumulator.
- The matching receiver is a separate future block, pbit_frame_rx.

## Test plan
- NUM_PBITS=7, DATA_WIDTH=3, pbits_in=7'b1111010, tx_ready=1, one start → beats 3'b010, 3'b111, 3'b001 in cycles t+1..t+3. tx_last is on beat 2; done pulses at t+4; frame_cnt=1.
- Same configuration with the macro → 4th beat 3'b100, tx_last only on that beat.
- tx_ready low for 5 cycles on beat 1 → tx_data holds 3'b111 with tx_valid=1 throughout. No beat is skipped or duplicated.
- start held high continuously → frames stream with no gap; frame_cnt increments once per NUM_BEATS cycles. Starts issued during a frame (excluding the final-handshake cycle) produce start_dropped pulses.
- rst pulsed during beat 1 → all outputs go to 0 immediately and no done pulse occurs. The next start yields a complete frame from beat 0.
- Default parameters (1369/30) → 46 beats. Beat 45 bits [29:19] are 0.
